// File: rtl/b_sbox.sv
// rtl/b_sbox.sv - AES forward S-box via composite-field inversion, registered output

module b_sbox (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] B,
  output logic [7:0] sub
);

  // GF(2^2) = GF(2)[w]/(w^2+w+1); element {a1,a0} = a1*w + a0
  function automatic logic [1:0] gf4_mul(input logic [1:0] a, input logic [1:0] b);
    return {(a[1] & b[1]) ^ (a[1] & b[0]) ^ (a[0] & b[1]),
            (a[1] & b[1]) ^ (a[0] & b[0])};
  endfunction

  // squaring doubles as inversion in GF(2^2) (a^3 = 1, and 0 maps to 0)
  function automatic logic [1:0] gf4_sq(input logic [1:0] a);
    return {a[1], a[1] ^ a[0]};
  endfunction

  function automatic logic [1:0] gf4_scl_w(input logic [1:0] a);
    return {a[1] ^ a[0], a[1]};
  endfunction

  function automatic logic [1:0] gf4_scl_w2(input logic [1:0] a);
    return {a[0], a[1] ^ a[0]};
  endfunction

  // GF(2^4) = GF(2^2)[y]/(y^2+y+w); Karatsuba form keeps three GF(2^2) multipliers
  function automatic logic [3:0] gf16_mul(input logic [3:0] a, input logic [3:0] b);
    logic [1:0] hh, ll, mm;
    hh = gf4_mul(a[3:2], b[3:2]);
    ll = gf4_mul(a[1:0], b[1:0]);
    mm = gf4_mul(a[3:2] ^ a[1:0], b[3:2] ^ b[1:0]);
    return {mm ^ ll, gf4_scl_w(hh) ^ ll};
  endfunction

  function automatic logic [3:0] gf16_sq(input logic [3:0] a);
    return {gf4_sq(a[3:2]), gf4_scl_w(gf4_sq(a[3:2])) ^ gf4_sq(a[1:0])};
  endfunction

  // scale by lambda = w*y, the constant term of the GF(2^8) extension polynomial
  function automatic logic [3:0] gf16_scl_l(input logic [3:0] a);
    return {gf4_scl_w(a[3:2] ^ a[1:0]), gf4_scl_w2(a[3:2])};
  endfunction

  function automatic logic [3:0] gf16_sq_scl(input logic [3:0] a);
    return gf16_scl_l(gf16_sq(a));
  endfunction

  // inverse of ah*y+al is (ah*y + ah+al) / (w*ah^2 + ah*al + al^2)
  function automatic logic [3:0] gf16_inv(input logic [3:0] a);
    logic [1:0] d, di;
    d  = gf4_scl_w(gf4_sq(a[3:2])) ^ gf4_mul(a[3:2], a[1:0]) ^ gf4_sq(a[1:0]);
    di = gf4_sq(d);
    return {gf4_mul(a[3:2], di), gf4_mul(a[3:2] ^ a[1:0], di)};
  endfunction

  // GF(2^8) = GF(2^4)[z]/(z^2+z+lambda); zero falls through to zero
  function automatic logic [7:0] gf256_inv(input logic [7:0] x);
    logic [3:0] d, di;
    d  = gf16_sq_scl(x[7:4]) ^ gf16_mul(x[7:4], x[3:0]) ^ gf16_sq(x[3:0]);
    di = gf16_inv(d);
    return {gf16_mul(x[7:4], di), gf16_mul(x[7:4] ^ x[3:0], di)};
  endfunction

  // tower multiply, only used while deriving the basis-change matrices
  function automatic logic [7:0] gf256_mul(input logic [7:0] a, input logic [7:0] b);
    logic [3:0] hh, ll, mm;
    hh = gf16_mul(a[7:4], b[7:4]);
    ll = gf16_mul(a[3:0], b[3:0]);
    mm = gf16_mul(a[7:4] ^ a[3:0], b[7:4] ^ b[3:0]);
    return {mm ^ ll, gf16_scl_l(hh) ^ ll};
  endfunction

  // 8x8 GF(2) matrix times vector; column i lives in m[8*i+7:8*i]
  function automatic logic [7:0] mat_apply(input logic [63:0] m, input logic [7:0] v);
    logic [63:0] mm;
    logic [7:0]  vv, r;
    mm = m;
    vv = v;
    r  = '0;
    for (int i = 0; i < 8; i++) begin
      r  = r ^ (mm[7:0] & {8{vv[0]}});
      mm = mm >> 8;
      vv = vv >> 1;
    end
    return r;
  endfunction

  // linear part of the affine map: s_i = v_i ^ v_(i+4) ^ v_(i+5) ^ v_(i+6) ^ v_(i+7)
  function automatic logic [7:0] affine_lin(input logic [7:0] v);
    return v ^ {v[3:0], v[7:4]} ^ {v[4:0], v[7:5]} ^ {v[5:0], v[7:6]} ^ {v[6:0], v[7]};
  endfunction

  // columns are beta^0..beta^7 for a tower element beta that is a root of x^8+x^4+x^3+x+1
  function automatic logic [63:0] tower_basis();
    logic [63:0] cols, found_cols;
    logic [7:0]  cand, p;
    logic        found;
    found      = 1'b0;
    found_cols = '0;
    for (int c = 2; c < 256; c++) begin
      cand = 8'(c);
      p    = 8'h01;
      cols = '0;
      for (int k = 0; k < 8; k++) begin
        cols = {p, cols[63:8]};
        p    = gf256_mul(p, cand);
      end
      if (!found && ((p ^ cols[39:32] ^ cols[31:24] ^ cols[15:8] ^ cols[7:0]) == 8'h00)) begin
        found      = 1'b1;
        found_cols = cols;
      end
    end
    return found_cols;
  endfunction

  // inverse basis change folded into the affine matrix, column by column
  function automatic logic [63:0] out_matrix(input logic [63:0] to_t);
    logic [63:0] cols;
    logic [7:0]  unit, col;
    cols = '0;
    unit = 8'h01;
    for (int j = 0; j < 8; j++) begin
      col = '0;
      for (int a = 0; a < 256; a++) begin
        if (mat_apply(to_t, 8'(a)) == unit) col = affine_lin(8'(a));
      end
      cols = {col, cols[63:8]};
      unit = unit << 1;
    end
    return cols;
  endfunction

  localparam logic [63:0] TO_TOWER   = tower_basis();
  localparam logic [63:0] FROM_TOWER = out_matrix(TO_TOWER);

  logic [7:0] tower_v;
  logic [7:0] tower_inv;
  logic [7:0] sub_d;
  logic [7:0] sub_q;

  // map into the tower field, invert there, map back through the merged affine matrix
  always_comb begin
    tower_v   = mat_apply(TO_TOWER, B);
    tower_inv = gf256_inv(tower_v);
    sub_d     = mat_apply(FROM_TOWER, tower_inv) ^ 8'h63;
  end

  // output register; reset clears it without waiting for a clock edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sub_q <= 8'h00;
    else     sub_q <= sub_d;
  end

  assign sub = sub_q;

endmodule

// File: tb/tb_b_sbox.sv
// tb/tb_b_sbox.sv - directed bench for b_sbox against a polynomial-basis S-box model

module tb_b_sbox;

  logic       clk;
  logic       rst;
  logic [7:0] B;
  logic [7:0] sub;

  int checks;
  int failures;
  int seen [256];

  b_sbox dut (
    .clk (clk),
    .rst (rst),
    .B   (B),
    .sub (sub)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = '0;
    x = a;
    y = b;
    for (int k = 0; k < 8; k++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1B) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] ref_sbox(input logic [7:0] a);
    logic [7:0] r;
    r = 8'h01;
    for (int k = 0; k < 254; k++) r = gmul(r, a);
    if (a == 8'h00) r = 8'h00;
    return r ^ {r[3:0], r[7:4]} ^ {r[4:0], r[7:5]} ^ {r[5:0], r[7:6]} ^ {r[6:0], r[7]} ^ 8'h63;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [7:0] b);
    B = b;
    @(posedge clk);
    #1;
  endtask

  logic [7:0] spot_in  [8];
  logic [7:0] spot_exp [8];
  int distinct;

  initial begin
    checks   = 0;
    failures = 0;
    spot_in  = '{8'h00, 8'h01, 8'h02, 8'h10, 8'h80, 8'hC9, 8'hFF, 8'h53};
    spot_exp = '{8'h63, 8'h7C, 8'h77, 8'hCA, 8'hCD, 8'hDD, 8'h16, 8'hED};
    for (int i = 0; i < 256; i++) seen[i] = 0;

    rst = 1'b1;
    B   = 8'h53;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_hold", sub, 8'h00);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("reset_release", sub, 8'hED);

    for (int i = 0; i < 256; i++) begin
      B = 8'(i);
      if (i == 100) begin
        #2 rst = 1'b1;
        #1 chk("async_reset", sub, 8'h00);
        #1 rst = 1'b0;
      end
      @(posedge clk);
      #1;
      if (i == 100) chk("reset_resume", sub, ref_sbox(8'(i)));
      chk($sformatf("sweep_%02h", i), sub, ref_sbox(8'(i)));
      seen[sub] = seen[sub] + 1;
    end

    distinct = 0;
    for (int i = 0; i < 256; i++) if (seen[i] == 1) distinct++;
    checks++;
    assert (distinct === 256) else begin
      failures++;
      $error("FAIL bijective: observed=%0d expected=256", distinct);
    end

    for (int i = 0; i < 8; i++) begin
      step(spot_in[i]);
      chk($sformatf("fips_%02h", spot_in[i]), sub, spot_exp[i]);
    end

    step(8'h00); chk("b2b_0", sub, 8'h63);
    step(8'hFF); chk("b2b_1", sub, 8'h16);
    step(8'h00); chk("b2b_2", sub, 8'h63);
    step(8'hFF); chk("b2b_3", sub, 8'h16);

    step(8'h5A); chk("nonzero_5a", sub, 8'hBE);
    step(8'h00); chk("zero_after_nonzero", sub, 8'h63);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
